test_usart: RTL and testbench

TEST_USART -- requirements
Module: test_usart

---
 rtl/test_usart.sv | 241 ++++++++++++++++++++++++
 tb/tb_test_usart.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/test_usart.sv
// 8E1 UART transmitter/receiver pair sharing one oversampling baud generator.
// The transmitter streams Data_Tx back-to-back while CLR is low; the receiver samples Rx at mid-bit.
module test_usart #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int OVS    = 16
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       CLR_Rec,
  input  logic       Rx,
  input  logic [7:0] Data_Tx,
  output logic       Tx,
  output logic       CLK_B,
  output logic [7:0] Data_Rx,
  output logic       Data_Ready,
  output logic       parity_err
);

  localparam int DIV = CLK_HZ / (BAUD * OVS);
  localparam int CW  = $clog2(DIV + 1);
  localparam int TW  = $clog2(OVS + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] DIV_HALF = CW'(DIV / 2);
  localparam logic [TW-1:0] OVS_LAST = TW'(OVS - 1);
  localparam logic [TW-1:0] MID      = TW'(OVS / 2 - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0] rst_sync_q, rst_sync_d, rx_rst_sync_q, rx_rst_sync_d;
  logic       rst, rx_rst, rx_clr_async;

  // Resets assert immediately but release two clocks later, in step with CLK.
  assign rx_clr_async = CLR | CLR_Rec;
  assign rst          = rst_sync_q[1];
  assign rx_rst       = rx_rst_sync_q[1];

  always_comb begin
    rst_sync_d    = {rst_sync_q[0], 1'b0};
    rx_rst_sync_d = {rx_rst_sync_q[0], 1'b0};
  end

  always_ff @(posedge CLK or posedge CLR)
    if (CLR) rst_sync_q <= 2'b11;
    else     rst_sync_q <= rst_sync_d;

  always_ff @(posedge CLK or posedge rx_clr_async)
    if (rx_clr_async) rx_rst_sync_q <= 2'b11;
    else              rx_rst_sync_q <= rx_rst_sync_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          clk_b_q, clk_b_d, tick;

  // CLK_B is derived from the next count so that it lines up with cnt_q.
  always_comb begin
    tick    = (cnt_q == DIV_LAST);
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    clk_b_d = (cnt_d < DIV_HALF);
  end

  always_ff @(posedge CLK or posedge rst)
    if (rst) begin
      cnt_q   <= '0;
      clk_b_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      clk_b_q <= clk_b_d;
    end

  assign CLK_B = clk_b_q;

  state_t        tx_state_q, tx_state_d;
  logic [TW-1:0] tx_tick_q, tx_tick_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          tx_par_q, tx_par_d, tx_q, tx_d;

  always_ff @(posedge CLK or posedge rst)
    if (rst) begin
      tx_state_q <= S_IDLE;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
    end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    if (tick) begin
      if (tx_state_q == S_IDLE) begin
        tx_state_d = S_START;
        tx_tick_d  = '0;
        tx_sh_d    = Data_Tx;
        tx_par_d   = ^Data_Tx;
      end else if (tx_tick_q == OVS_LAST) begin
        tx_tick_d = '0;
        case (tx_state_q)
          S_START: begin
            tx_state_d = S_DATA;
            tx_bit_d   = '0;
          end
          S_DATA: begin
            tx_sh_d  = tx_sh_q >> 1;
            tx_bit_d = tx_bit_q + 1'b1;
            if (tx_bit_q == 3'd7) tx_state_d = S_PARITY;
          end
          S_PARITY: tx_state_d = S_STOP;
          default: begin
            tx_state_d = S_START;
            tx_sh_d    = Data_Tx;
            tx_par_d   = ^Data_Tx;
          end
        endcase
      end else begin
        tx_tick_d = tx_tick_q + 1'b1;
      end
    end
  end

  // Line level is decoded from the next state so Tx comes straight from a flop.
  always_comb begin
    case (tx_state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = tx_sh_d[0];
      S_PARITY: tx_d = tx_par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  assign Tx = tx_q;

  state_t        rx_state_q, rx_state_d;
  logic [TW-1:0] rx_tick_q, rx_tick_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d, data_q, data_d;
  logic          rx_par_q, rx_par_d, ready_q, ready_d, perr_q, perr_d;
  logic          rx_meta_q, rx_sync_q, rx_mid;

  always_ff @(posedge CLK or posedge rx_rst)
    if (rx_rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_par_q   <= 1'b0;
      data_q     <= '0;
      ready_q    <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      rx_meta_q  <= Rx;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_par_q   <= rx_par_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      perr_q     <= perr_d;
    end

  // START is checked half a bit in; every later bit is sampled one full bit after the last.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_mid     = 1'b0;
    if (tick) begin
      case (rx_state_q)
        S_IDLE:
          if (!rx_sync_q) begin
            rx_state_d = S_START;
            rx_tick_d  = '0;
          end
        S_START:
          if (rx_tick_q == MID) begin
            rx_tick_d  = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
          end else begin
            rx_tick_d = rx_tick_q + 1'b1;
          end
        default:
          if (rx_tick_q == OVS_LAST) begin
            rx_mid    = 1'b1;
            rx_tick_d = '0;
            case (rx_state_q)
              S_DATA: begin
                rx_bit_d = rx_bit_q + 1'b1;
                if (rx_bit_q == 3'd7) rx_state_d = S_PARITY;
              end
              S_PARITY: rx_state_d = S_STOP;
              default:  rx_state_d = S_IDLE;
            endcase
          end else begin
            rx_tick_d = rx_tick_q + 1'b1;
          end
      endcase
    end
  end

  always_comb begin
    rx_sh_d  = rx_sh_q;
    rx_par_d = rx_par_q;
    data_d   = data_q;
    ready_d  = ready_q;
    perr_d   = perr_q;
    if (rx_state_q == S_IDLE && rx_state_d == S_START) ready_d = 1'b0;
    if (rx_mid) begin
      case (rx_state_q)
        S_DATA:   rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
        S_PARITY: rx_par_d = rx_sync_q;
        S_STOP: begin
          data_d  = rx_sh_q;
          ready_d = 1'b1;
          perr_d  = (rx_par_q != ^rx_sh_q) | ~rx_sync_q;
        end
        default: ;
      endcase
    end
  end

  assign Data_Rx    = data_q;
  assign Data_Ready = ready_q;
  assign parity_err = perr_q;

endmodule

// File: tb/tb_test_usart.sv
// Self-checking bench for test_usart: loopback streams, driven Rx frames and reset corner cases.
// Uses a small divisor (DIV = 4, 64 clocks per bit) to keep the run short.
module tb_test_usart;

  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD   = 781_250;
  localparam int OVS    = 16;
  localparam int BIT    = 64;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic       CLR_Rec = 1'b0;
  logic       loopback = 1'b0;
  logic       rx_drv = 1'b1;
  logic [7:0] Data_Tx = 8'h00;
  logic       Rx, Tx, CLK_B, Data_Ready, parity_err;
  logic [7:0] Data_Rx;

  int cyc = 0;
  int checkCount = 0;
  int passCount = 0;

  assign Rx = loopback ? Tx : rx_drv;

  test_usart #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(OVS)) dut (
    .CLK(CLK), .CLR(CLR), .CLR_Rec(CLR_Rec), .Rx(Rx), .Data_Tx(Data_Tx),
    .Tx(Tx), .CLK_B(CLK_B), .Data_Rx(Data_Rx), .Data_Ready(Data_Ready),
    .parity_err(parity_err)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference model: frame bits in time order, index 0 = start bit.
  function automatic logic [10:0] frameBits(input logic [7:0] d, input logic par, input logic stop);
    return {stop, par, d, 1'b0};
  endfunction

  function automatic logic evenPar(input logic [7:0] d);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(d[i]);
    return logic'(n % 2);
  endfunction

  task automatic waitCycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic waitReady(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (Data_Ready !== lvl && n < budget) begin
      @(negedge CLK);
      n++;
    end
    checkOutput({tag, "_wait"}, 32'(Data_Ready === lvl), 32'd1);
  endtask

  task automatic waitTxFall(input int budget, input string tag, output int t);
    int n = 0;
    while (Tx !== 1'b0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    checkOutput({tag, "_txfall"}, 32'(Tx === 1'b0), 32'd1);
    t = cyc;
  endtask

  task automatic applyStimulus(input logic [10:0] f, input int from, input int upto);
    for (int i = from; i <= upto; i++) begin
      rx_drv = f[i];
      waitCycles(BIT);
    end
  endtask

  initial begin
    logic [10:0] f;
    logic [7:0]  a, b, d;
    logic        par, stop, expPerr;
    int          t0, t1, t2, lat, highs, mode;

    $display("[TB] start");
    waitCycles(10);
    checkOutput("rst_tx", 32'(Tx), 32'd1);
    checkOutput("rst_clkb", 32'(CLK_B), 32'd0);
    checkOutput("rst_data", 32'(Data_Rx), 32'd0);
    checkOutput("rst_ready", 32'(Data_Ready), 32'd0);
    checkOutput("rst_perr", 32'(parity_err), 32'd0);

    // Loopback of 8'h01: bit-level frame check and ready latency.
    loopback = 1'b1;
    Data_Tx  = 8'h01;
    CLR      = 1'b0;
    waitTxFall(50, "lb01", t0);
    f = frameBits(8'h01, evenPar(8'h01), 1'b1);
    waitCycles(BIT / 2);
    for (int i = 0; i < 11; i++) begin
      checkOutput($sformatf("tx_bit%0d", i), 32'(Tx), 32'(f[i]));
      if (i < 10) waitCycles(BIT);
    end
    waitReady(1'b1, 100, "lb01_ready");
    lat = cyc - t0;
    checkOutput("ready_latency_ok", 32'(lat >= 660 && lat <= 700), 32'd1);
    checkOutput("lb01_data", 32'(Data_Rx), 32'h01);
    checkOutput("lb01_perr", 32'(parity_err), 32'd0);

    highs = 0;
    for (int i = 0; i < 40; i++) begin
      waitCycles(1);
      highs += int'(CLK_B);
    end
    checkOutput("clkb_duty", 32'(highs), 32'd20);

    // CLR pulsed per value; Data_Tx changed mid-frame must only affect the following frame.
    for (int i = 1; i <= 16; i++) begin
      CLR = 1'b1;
      waitCycles(3);
      checkOutput("clr_ready", 32'(Data_Ready), 32'd0);
      checkOutput("clr_data", 32'(Data_Rx), 32'd0);
      a = 8'(i);
      Data_Tx = a;
      CLR = 1'b0;
      waitCycles(200);
      b = 8'($urandom);
      Data_Tx = b;
      waitReady(1'b1, 700, "seq_a");
      checkOutput($sformatf("seq_a_%0d", i), 32'(Data_Rx), 32'(a));
      checkOutput("seq_a_perr", 32'(parity_err), 32'd0);
      waitReady(1'b0, 200, "seq_drop");
      waitReady(1'b1, 800, "seq_b");
      checkOutput($sformatf("seq_b_%0d", i), 32'(Data_Rx), 32'(b));
      checkOutput("seq_b_perr", 32'(parity_err), 32'd0);
    end

    // Externally driven frames with random parity/stop corruption.
    CLR = 1'b1;
    loopback = 1'b0;
    rx_drv = 1'b1;
    waitCycles(3);
    CLR = 1'b0;
    waitCycles(10);
    for (int k = 0; k < 12; k++) begin
      if (k == 0) begin
        d = 8'hA5; par = 1'b1; stop = 1'b1;
      end else begin
        d = 8'($urandom);
        mode = int'($urandom_range(0, 3));
        par  = evenPar(d) ^ (mode == 0);
        stop = (mode != 1);
      end
      expPerr = (par != evenPar(d)) || !stop;
      f = frameBits(d, par, stop);
      applyStimulus(f, 0, 2);
      checkOutput("drv_ready_midframe", 32'(Data_Ready), 32'd0);
      applyStimulus(f, 3, 10);
      rx_drv = 1'b1;
      checkOutput($sformatf("drv_data_%0d", k), 32'(Data_Rx), 32'(d));
      checkOutput($sformatf("drv_perr_%0d", k), 32'(parity_err), 32'(expPerr));
      if (stop) checkOutput($sformatf("drv_ready_%0d", k), 32'(Data_Ready), 32'd1);
      waitCycles(40);
    end

    // CLR_Rec clears receiver outputs; a short low glitch is rejected as a false start.
    CLR_Rec = 1'b1;
    waitCycles(3);
    checkOutput("clrrec_data", 32'(Data_Rx), 32'd0);
    checkOutput("clrrec_ready", 32'(Data_Ready), 32'd0);
    checkOutput("clrrec_perr", 32'(parity_err), 32'd0);
    CLR_Rec = 1'b0;
    waitCycles(5);
    rx_drv = 1'b0;
    waitCycles(12);
    rx_drv = 1'b1;
    waitCycles(200);
    checkOutput("glitch_ready", 32'(Data_Ready), 32'd0);
    checkOutput("glitch_data", 32'(Data_Rx), 32'd0);
    d = 8'($urandom);
    applyStimulus(frameBits(d, evenPar(d), 1'b1), 0, 10);
    checkOutput("post_glitch_data", 32'(Data_Rx), 32'(d));
    checkOutput("post_glitch_ready", 32'(Data_Ready), 32'd1);

    // CLR during the DATA phase aborts the frame at once.
    loopback = 1'b1;
    CLR = 1'b1;
    Data_Tx = 8'h00;
    waitCycles(3);
    CLR = 1'b0;
    waitTxFall(50, "abort", t0);
    waitCycles(BIT / 2 + 3 * BIT);
    checkOutput("tx_in_data", 32'(Tx), 32'd0);
    CLR = 1'b1;
    #1;
    checkOutput("abort_tx", 32'(Tx), 32'd1);
    checkOutput("abort_ready", 32'(Data_Ready), 32'd0);
    waitCycles(5);
    a = 8'($urandom);
    Data_Tx = a;
    CLR = 1'b0;
    waitReady(1'b1, 800, "after_abort");
    checkOutput("after_abort_data", 32'(Data_Rx), 32'(a));
    checkOutput("after_abort_perr", 32'(parity_err), 32'd0);

    // CLR_Rec after receiving 8'h3C leaves the transmitter running undisturbed.
    CLR = 1'b1;
    Data_Tx = 8'h3C;
    waitCycles(3);
    CLR = 1'b0;
    waitTxFall(50, "lb3c", t1);
    waitReady(1'b1, 800, "lb3c");
    checkOutput("lb3c_data", 32'(Data_Rx), 32'h3C);
    CLR_Rec = 1'b1;
    waitCycles(4);
    checkOutput("lb3c_clr_data", 32'(Data_Rx), 32'd0);
    checkOutput("lb3c_clr_ready", 32'(Data_Ready), 32'd0);
    checkOutput("lb3c_clr_perr", 32'(parity_err), 32'd0);
    CLR_Rec = 1'b0;
    waitTxFall(100, "lb3c_next", t2);
    checkOutput("tx_frame_period", 32'(t2 - t1), 32'(11 * BIT));
    waitReady(1'b1, 800, "lb3c_again");
    checkOutput("lb3c_again_data", 32'(Data_Rx), 32'h3C);
    checkOutput("lb3c_again_perr", 32'(parity_err), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
